// File: rtl/img_band_remap_pkg.sv
// img_band_remap_pkg: colour names and commit-state type shared by the band remapper.
package img_band_remap_pkg;
  localparam logic [2:0] BLACK   = 3'd0;
  localparam logic [2:0] BLUE    = 3'd1;
  localparam logic [2:0] GREEN   = 3'd2;
  localparam logic [2:0] CYAN    = 3'd3;
  localparam logic [2:0] RED     = 3'd4;
  localparam logic [2:0] MAGENTA = 3'd5;
  localparam logic [2:0] YELLOW  = 3'd6;
  localparam logic [2:0] WHITE   = 3'd7;
  typedef enum logic {IDLE, PEND} commit_state_t;
endpackage

// File: rtl/img_band_remap_if.sv
// img_band_remap_if: pixel stream, configuration and status signals of the band remapper.
interface img_band_remap_if #(
  parameter int RGB_W   = 3,
  parameter int POS_W   = 10,
  parameter int N_BANDS = 8
);
  logic                       pix_valid_i;
  logic [RGB_W-1:0]           rgb_i;
  logic [POS_W-1:0]           pos_i;
  logic                       frame_start_i;
  logic                       cfg_we_i;
  logic [$clog2(N_BANDS)-1:0] cfg_band_i;
  logic [RGB_W-1:0]           cfg_src_i;
  logic [RGB_W-1:0]           cfg_dst_i;
  logic                       cfg_commit_i;
  logic                       bypass_i;
  logic                       pix_valid_o;
  logic [RGB_W-1:0]           rgb_o;
  logic                       commit_pend_o;
  logic [15:0]                hit_cnt_o;
  modport master (
    output pix_valid_i, rgb_i, pos_i, frame_start_i, cfg_we_i, cfg_band_i, cfg_src_i,
           cfg_dst_i, cfg_commit_i, bypass_i,
    input  pix_valid_o, rgb_o, commit_pend_o, hit_cnt_o
  );
  modport slave (
    input  pix_valid_i, rgb_i, pos_i, frame_start_i, cfg_we_i, cfg_band_i, cfg_src_i,
           cfg_dst_i, cfg_commit_i, bypass_i,
    output pix_valid_o, rgb_o, commit_pend_o, hit_cnt_o
  );
endinterface

// File: rtl/band_lut.sv
// band_lut: shadow/active colour LUT pair; a copy captures a same-cycle shadow write.
module band_lut #(
  parameter int RGB_W   = 3,
  parameter int N_BANDS = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       we,
  input  logic [$clog2(N_BANDS)-1:0] wband,
  input  logic [RGB_W-1:0]           wsrc,
  input  logic [RGB_W-1:0]           wdst,
  input  logic                       copy,
  input  logic [$clog2(N_BANDS)-1:0] rband,
  input  logic [RGB_W-1:0]           rsrc,
  output logic [RGB_W-1:0]           rdata
);
  localparam int N_COL = 2 ** RGB_W;
  logic [RGB_W-1:0] shadow [N_BANDS][N_COL];
  logic [RGB_W-1:0] shadow_nxt [N_BANDS][N_COL];
  logic [RGB_W-1:0] active [N_BANDS][N_COL];
  always_comb begin
    shadow_nxt = shadow;
    if (we) shadow_nxt[wband][wsrc] = wdst;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int b = 0; b < N_BANDS; b++)
        for (int s = 0; s < N_COL; s++) begin
          shadow[b][s] <= RGB_W'(s);
          active[b][s] <= RGB_W'(s);
        end
    end else begin
      shadow <= shadow_nxt;
      if (copy) active <= shadow_nxt;
    end
  end
  assign rdata = active[rband][rsrc];
endmodule

// File: rtl/img_band_remap.sv
// img_band_remap: two-stage per-band colour remapper with frame-aligned LUT commit and hit counter.
module img_band_remap
  import img_band_remap_pkg::*;
#(
  parameter int RGB_W   = 3,
  parameter int POS_W   = 10,
  parameter int N_BANDS = 8,
  parameter int BAND_W  = 80
) (
  input logic              clk,
  input logic              rst_n,
  img_band_remap_if.slave  bus
);
  localparam int BW = $clog2(N_BANDS);
  commit_state_t    state, state_nxt;
  logic             copy, in_range, hit;
  logic [BW-1:0]    band, s1_band;
  logic             s1_valid, s1_inr, s1_byp;
  logic [RGB_W-1:0] s1_rgb, lut_rgb, remap;
  logic [15:0]      run_cnt, run_nxt;
  always_comb begin
    copy      = bus.frame_start_i && (state == PEND || bus.cfg_commit_i);
    state_nxt = bus.frame_start_i ? IDLE : (bus.cfg_commit_i ? PEND : state);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end
  assign bus.commit_pend_o = (state == PEND);
  // band = pos / BAND_W via constant boundary compares
  always_comb begin
    band = '0;
    for (int k = 1; k < N_BANDS; k++)
      if (int'(bus.pos_i) >= k * BAND_W) band = BW'(k);
  end
  assign in_range = int'(bus.pos_i) < N_BANDS * BAND_W;
  band_lut #(.RGB_W(RGB_W), .N_BANDS(N_BANDS)) u_lut (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (bus.cfg_we_i),
    .wband (bus.cfg_band_i),
    .wsrc  (bus.cfg_src_i),
    .wdst  (bus.cfg_dst_i),
    .copy  (copy),
    .rband (s1_band),
    .rsrc  (s1_rgb),
    .rdata (lut_rgb)
  );
  assign remap   = (s1_inr && !s1_byp) ? lut_rgb : s1_rgb;
  assign hit     = s1_valid && s1_inr && !s1_byp && (lut_rgb != s1_rgb);
  assign run_nxt = (run_cnt == 16'hFFFF) ? run_cnt : run_cnt + 16'(hit);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid        <= 1'b0;
      s1_inr          <= 1'b0;
      s1_byp          <= 1'b0;
      s1_band         <= '0;
      s1_rgb          <= '0;
      bus.pix_valid_o <= 1'b0;
      bus.rgb_o       <= '0;
      bus.hit_cnt_o   <= '0;
      run_cnt         <= '0;
    end else begin
      s1_valid        <= bus.pix_valid_i;
      s1_inr          <= in_range;
      s1_byp          <= bus.bypass_i;
      s1_band         <= band;
      s1_rgb          <= bus.rgb_i;
      bus.pix_valid_o <= s1_valid;
      if (s1_valid) bus.rgb_o <= remap;
      run_cnt         <= bus.frame_start_i ? 16'd0 : run_nxt;
      if (bus.frame_start_i) bus.hit_cnt_o <= run_nxt;
    end
  end
endmodule

// File: tb/tb_img_band_remap.sv
// tb_img_band_remap: directed stimulus with an expected-colour queue checked by a separate monitor.
module tb_img_band_remap;
  import img_band_remap_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [2:0] exp_q [$];
  img_band_remap_if bus ();
  img_band_remap dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (rst_n && bus.pix_valid_o) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pix_unexpected rgb_o=%0d with no pixel expected", bus.rgb_o);
      end else begin
        logic [2:0] e;
        e = exp_q.pop_front();
        if (bus.rgb_o !== e) begin
          n_fail++;
          $display("FAIL pix_rgb got=%0d want=%0d at %0t", bus.rgb_o, e, $time);
        end
      end
    end
  end
  task automatic check(input string name, input int act, input int want);
    n_chk++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", name, act, want);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic pix(input int p, input logic [2:0] c, input logic b, input logic [2:0] e);
    bus.pix_valid_i = 1'b1;
    bus.pos_i       = 10'(p);
    bus.rgb_i       = c;
    bus.bypass_i    = b;
    exp_q.push_back(e);
    tick(1);
    bus.pix_valid_i = 1'b0;
    bus.bypass_i    = 1'b0;
  endtask
  task automatic frame();
    bus.frame_start_i = 1'b1;
    tick(1);
    bus.frame_start_i = 1'b0;
  endtask
  task automatic wr(input int b, input logic [2:0] s, input logic [2:0] d);
    bus.cfg_we_i   = 1'b1;
    bus.cfg_band_i = 3'(b);
    bus.cfg_src_i  = s;
    bus.cfg_dst_i  = d;
    tick(1);
    bus.cfg_we_i   = 1'b0;
  endtask
  task automatic commit();
    bus.cfg_commit_i = 1'b1;
    tick(1);
    bus.cfg_commit_i = 1'b0;
  endtask
  initial begin
    bus.pix_valid_i = 0; bus.rgb_i = 0; bus.pos_i = 0; bus.frame_start_i = 0;
    bus.cfg_we_i = 0; bus.cfg_band_i = 0; bus.cfg_src_i = 0; bus.cfg_dst_i = 0;
    bus.cfg_commit_i = 0; bus.bypass_i = 0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    check("rst_valid", int'(bus.pix_valid_o), 0);
    check("rst_rgb", int'(bus.rgb_o), 0);
    check("rst_pend", int'(bus.commit_pend_o), 0);
    check("rst_hits", int'(bus.hit_cnt_o), 0);
    frame();
    for (int p = 0; p < 640; p++) pix(p, MAGENTA, 1'b0, MAGENTA);
    tick(3);
    frame();
    check("ident_hits", int'(bus.hit_cnt_o), 0);
    wr(0, BLACK, BLUE);
    pix(10, BLACK, 1'b0, BLACK);
    commit();
    check("pend_set", int'(bus.commit_pend_o), 1);
    pix(10, BLACK, 1'b0, BLACK);
    tick(3);
    frame();
    check("pend_clear", int'(bus.commit_pend_o), 0);
    check("pre_commit_hits", int'(bus.hit_cnt_o), 0);
    pix(10, BLACK, 1'b0, BLUE);
    pix(90, BLACK, 1'b0, BLACK);
    pix(10, BLACK, 1'b1, BLACK);
    tick(3);
    bus.cfg_we_i = 1'b1; bus.cfg_band_i = 3'd7; bus.cfg_src_i = CYAN; bus.cfg_dst_i = YELLOW;
    bus.cfg_commit_i = 1'b1;
    frame();
    bus.cfg_we_i = 1'b0; bus.cfg_commit_i = 1'b0;
    check("coincide_pend", int'(bus.commit_pend_o), 0);
    check("one_hit", int'(bus.hit_cnt_o), 1);
    pix(639, CYAN, 1'b0, YELLOW);
    pix(560, CYAN, 1'b0, YELLOW);
    pix(559, CYAN, 1'b0, CYAN);
    pix(640, CYAN, 1'b0, CYAN);
    pix(1023, CYAN, 1'b0, CYAN);
    pix(10, CYAN, 1'b0, CYAN);
    tick(3);
    frame();
    check("band7_hits", int'(bus.hit_cnt_o), 2);
    for (int i = 0; i < 70000; i++) pix(10, BLACK, 1'b0, BLUE);
    tick(3);
    frame();
    check("sat_hits", int'(bus.hit_cnt_o), 32'hFFFF);
    for (int i = 0; i < 5; i++) pix(10, BLACK, 1'b1, BLACK);
    tick(3);
    frame();
    check("bypass_hits", int'(bus.hit_cnt_o), 0);
    wr(0, BLACK, GREEN);
    commit();
    check("pend_before_rst", int'(bus.commit_pend_o), 1);
    bus.pix_valid_i = 1'b1; bus.pos_i = 10'd10; bus.rgb_i = BLACK;
    tick(1);
    bus.pix_valid_i = 1'b0;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    check("rst_pend_drop", int'(bus.commit_pend_o), 0);
    check("rst_valid_drop", int'(bus.pix_valid_o), 0);
    tick(2);
    check("rst_no_emerge", int'(bus.pix_valid_o), 0);
    frame();
    pix(10, BLACK, 1'b0, BLACK);
    pix(639, CYAN, 1'b0, CYAN);
    tick(3);
    bus.cfg_commit_i = 1'b1;
    frame();
    bus.cfg_commit_i = 1'b0;
    pix(10, BLACK, 1'b0, BLACK);
    tick(3);
    frame();
    check("rst_ident_hits", int'(bus.hit_cnt_o), 0);
    tick(5);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/img_band_remap.md
IMG_BAND_REMAP -- requirements
Module: img_band_remap

Interface
REQ-001 Parameter RGB_W, default 3, SHALL set colour width in bits; the LUT has 2^RGB_W source entries per band.
REQ-002 Parameter POS_W, default 10, SHALL set pixel position width.
REQ-003 Parameter N_BANDS, default 8, SHALL set the number of position bands.
REQ-004 Parameter BAND_W, default 80, SHALL set the width of each band in pixels; N_BANDS*BAND_W SHALL be <= 2^POS_W.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 pix_valid_i  in  1  pixel qualifier.
REQ-008 rgb_i  in  RGB_W  source colour.
REQ-009 pos_i  in  POS_W  pixel position along the line.
REQ-010 frame_start_i  in  1  one-cycle pulse at start of frame.
REQ-011 cfg_we_i  in  1  shadow LUT write strobe.
REQ-012 cfg_band_i  in  clog2(N_BANDS)  band index to write.
REQ-013 cfg_src_i  in  RGB_W  source colour to write.
REQ-014 cfg_dst_i  in  RGB_W  replacement colour.
REQ-015 cfg_commit_i  in  1  request shadow-to-active copy at next frame_start_i.
REQ-016 bypass_i  in  1  when high, rgb passes unmodified.
REQ-017 pix_valid_o  out  1  output qualifier.
REQ-018 rgb_o  out  RGB_W  remapped colour.
REQ-019 commit_pend_o  out  1  commit requested, not yet applied.
REQ-020 hit_cnt_o  out  16  count of remapped pixels in the previous frame.

Function
REQ-021 Band index SHALL be pos_i / BAND_W, computed by comparison against constant boundaries k*BAND_W; no divider.
REQ-022 pos_i >= N_BANDS*BAND_W SHALL be out-of-range: pixel passes unmodified and is not counted.
REQ-023 Pipeline SHALL be exactly 2 cycles: stage 1 registers band index, in-range flag and rgb; stage 2 reads the active LUT and registers rgb_o.
REQ-024 pix_valid_o SHALL equal pix_valid_i delayed 2 cycles; rgb_o is don't-care but held stable when pix_valid_o is low.
REQ-025 Output SHALL be active_lut[band][rgb]; bypass_i, sampled with the pixel at stage 1, forces the source colour.
REQ-026 A "hit" SHALL be a valid, in-range, non-bypassed pixel whose output differs from its source.
REQ-027 cfg_we_i SHALL write only the shadow LUT; the active LUT never changes mid-frame.
REQ-028 Commit FSM SHALL have states IDLE and PEND: IDLE->PEND on cfg_commit_i; PEND->IDLE on frame_start_i, copying the full shadow LUT to active in that cycle.
REQ-029 commit_pend_o SHALL be high exactly in state PEND.
REQ-030 If cfg_commit_i and frame_start_i coincide in IDLE, the copy SHALL occur at that frame_start_i.
REQ-031 If cfg_we_i coincides with the copy, the copy SHALL include the new write.
REQ-032 The first pixel entering stage 1 in the cycle after the copy SHALL use the new table.
REQ-033 The hit counter SHALL saturate at 16'hFFFF and SHALL never wrap.
REQ-034 On frame_start_i, hit_cnt_o SHALL load the running count (including any hit completing that cycle) and the running count SHALL clear.

Reset
REQ-035 When rst_n is low at a clock edge, all of the following SHALL clear:
- pix_valid_o, rgb_o, stage registers and running count -> 0;
- hit_cnt_o -> 0;
- FSM -> IDLE.
REQ-036 Reset SHALL load both LUTs with identity (dst = src), so the block is transparent after reset.
REQ-037 Reset asserted mid-frame SHALL discard in-flight pixels and any pending commit.

Structure
REQ-038 A shared package SHALL hold the colour localparams (BLACK..WHITE) and the commit-state enum.
REQ-039 The LUT pair (shadow/active, write port, bulk copy, read port) SHALL be a sub-module named band_lut.

Verification
REQ-040 After reset, drive valid pixels rgb 3'b101 at pos 0..639 -> rgb_o 3'b101 two cycles later, hit_cnt_o 0 after the next frame_start_i.
REQ-041 Write band 0 src 000 -> dst 001, commit, pulse frame_start_i, then drive pos 10 rgb 000 -> rgb_o 001 and commit_pend_o low; pos 90 rgb 000 -> rgb_o 000.
REQ-042 Write without commit, or commit then mid-frame pixels before frame_start_i -> output unchanged until the frame_start_i.
REQ-043 Drive pos 640 and pos 1023 with a mapped colour -> passthrough, no hit counted; drive pos 639 -> band 7 mapping applied.
REQ-044 Drive 70000 hits in one frame -> hit_cnt_o = 16'hFFFF after frame_start_i; bypass_i high -> no hits counted.
REQ-045 Assert rst_n low with commit pending and pixels in flight -> commit_pend_o 0, pix_valid_o 0, LUT identity.
